// File: rtl/servo_pkg.sv
// servo_pkg: shared types and default timing constants for the servo pulse scheduler.
//   state_e         - scheduler FSM states (IDLE, PULSE, GAP, FWAIT)
//   SEL_W           - select width for the default 2-way leg demux
//   DEF_*           - default channel count and timing in clocks
package servo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    FWAIT = 2'd3
  } state_e;

  localparam int DEF_NUM_CH      = 2;
  localparam int SEL_W           = $clog2(DEF_NUM_CH);
  localparam int DEF_SLOT_TICKS  = 2500;
  localparam int DEF_FRAME_TICKS = 20000;
  localparam int DEF_DEFAULT_W   = 1500;

endpackage

// File: rtl/servo_width_regfile.sv
// servo_width_regfile: per-channel pulse-width registers.
//   clk, rst_n        - clock, synchronous active-low reset (widths -> DEFAULT_W)
//   wr_en/wr_ch/wr_width - write port; out-of-range channel indices are dropped
//   rd_ch/rd_width    - combinational read port, write-first: a write to the
//                       channel being read shows up on rd_width in the same cycle
module servo_width_regfile
  import servo_pkg::*;
#(
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int CNT_W     = 16,
  parameter int DEFAULT_W = DEF_DEFAULT_W,
  parameter int SW        = $clog2(NUM_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [SW-1:0]    wr_ch,
  input  logic [CNT_W-1:0] wr_width,
  input  logic [SW-1:0]    rd_ch,
  output logic [CNT_W-1:0] rd_width
);

  logic [CNT_W-1:0] w_q [NUM_CH];
  logic             wr_ok;

  assign wr_ok = wr_en && (int'(wr_ch) < NUM_CH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) w_q[i] <= CNT_W'(DEFAULT_W);
    end else if (wr_ok) begin
      w_q[wr_ch] <= wr_width;
    end
  end

  // Bypass so a slot starting on the same edge as a write latches the new value.
  always_comb begin
    rd_width = w_q[rd_ch];
    if (wr_ok && (wr_ch == rd_ch)) rd_width = wr_width;
  end

endmodule

// File: rtl/servo_pulse_sched.sv
// servo_pulse_sched: time-multiplexes one servo pulse generator over NUM_CH
// channels through an external 1-to-N demux. Each frame is FRAME_TICKS clocks:
// NUM_CH slots of SLOT_TICKS clocks (pulse then gap), then a wait to frame end.
//   clk, rst_n   - clock, synchronous active-low reset
//   enable       - run request, only looked at on frame boundaries
//   wr_en/wr_ch/wr_width - width write strobe. There is no ready: every strobe
//                  is accepted in the cycle it is high; invalid channels are dropped.
//   pulse, sel   - registered demux data and select
//   frame_start  - one-cycle strobe on the first cycle of each frame
//   busy         - high while a frame is in progress
//   dbg_state    - current FSM state, for observation only
module servo_pulse_sched
  import servo_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int CNT_W       = 16,
  parameter int SLOT_TICKS  = DEF_SLOT_TICKS,
  parameter int FRAME_TICKS = DEF_FRAME_TICKS,
  parameter int DEFAULT_W   = DEF_DEFAULT_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      wr_en,
  input  logic [$clog2(NUM_CH)-1:0] wr_ch,
  input  logic [CNT_W-1:0]          wr_width,
  output logic                      pulse,
  output logic [$clog2(NUM_CH)-1:0] sel,
  output logic                      frame_start,
  output logic                      busy,
  output state_e                    dbg_state
);

  localparam int               SW         = $clog2(NUM_CH);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_TICKS - 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_TICKS - 1);
  localparam logic [SW-1:0]    LAST_CH    = SW'(NUM_CH - 1);

  state_e           state;
  logic [CNT_W-1:0] slot_cnt;   // cycle index within the current slot
  logic [CNT_W-1:0] frm_cnt;    // cycle index within the current frame
  logic [CNT_W-1:0] act_w;      // shadow width of the slot in progress
  logic [CNT_W-1:0] rd_width;
  logic [CNT_W-1:0] lat_w;
  logic [CNT_W-1:0] slot_nxt;
  logic [SW-1:0]    nxt_ch;
  logic             in_slot;
  logic             slot_end;
  logic             frame_end;

  assign dbg_state = state;

  // Channel whose slot would start on the next boundary: the following channel
  // while slots are running, channel 0 for a new frame.
  always_comb begin
    in_slot   = (state == PULSE) || (state == GAP);
    nxt_ch    = (in_slot && (sel != LAST_CH)) ? (sel + SW'(1)) : '0;
    // Clamp keeps at least one low cycle at the end of each slot, so sel only
    // ever moves while pulse is low.
    lat_w     = (rd_width > SLOT_LAST) ? SLOT_LAST : rd_width;
    slot_nxt  = slot_cnt + CNT_W'(1);
    slot_end  = in_slot && (slot_cnt == SLOT_LAST);
    frame_end = (state != IDLE) && (frm_cnt == FRAME_LAST);
  end

  servo_width_regfile #(
    .NUM_CH   (NUM_CH),
    .CNT_W    (CNT_W),
    .DEFAULT_W(DEFAULT_W),
    .SW       (SW)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_ch   (wr_ch),
    .wr_width(wr_width),
    .rd_ch   (nxt_ch),
    .rd_width(rd_width)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      pulse       <= 1'b0;
      sel         <= '0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      slot_cnt    <= '0;
      frm_cnt     <= '0;
      act_w       <= '0;
    end else begin
      frame_start <= 1'b0;
      if ((state == IDLE && enable) || (frame_end && enable)) begin
        // New frame, slot 0 starts on this edge.
        frame_start <= 1'b1;
        busy        <= 1'b1;
        sel         <= '0;
        frm_cnt     <= '0;
        slot_cnt    <= '0;
        act_w       <= lat_w;
        pulse       <= (lat_w != '0);
        state       <= (lat_w != '0) ? PULSE : GAP;
      end else if (frame_end) begin
        state    <= IDLE;
        busy     <= 1'b0;
        sel      <= '0;
        pulse    <= 1'b0;
        frm_cnt  <= '0;
        slot_cnt <= '0;
      end else if (state != IDLE) begin
        frm_cnt <= frm_cnt + CNT_W'(1);
        if (slot_end) begin
          slot_cnt <= '0;
          if (sel == LAST_CH) begin
            state <= FWAIT;
            pulse <= 1'b0;
          end else begin
            sel   <= nxt_ch;
            act_w <= lat_w;
            pulse <= (lat_w != '0);
            state <= (lat_w != '0) ? PULSE : GAP;
          end
        end else if (in_slot) begin
          slot_cnt <= slot_nxt;
          pulse    <= (slot_nxt < act_w);
          state    <= (slot_nxt < act_w) ? PULSE : GAP;
        end
      end
    end
  end

endmodule
